// File: rtl/gabor_conv_pipe_if.sv
// -----------------------------------------------------------------------------
// gabor_conv_pipe_if
//
// Purpose: groups the window input stream, the coefficient write port and the
// result output stream of gabor_conv_pipe into one bundle.
//
// Handshake semantics (both streams): a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and its payload
// steady until that transfer; ready may depend combinationally on the sink's
// state, and valid must not depend on ready.
//
// Signals:
//   in_valid / in_ready / in_window   window stream, pixel 0 at the LSBs
//   coeff_we / coeff_addr / coeff_wdata   coefficient bank write port
//   out_valid / out_ready / out_data / out_sat   result stream
//
// Modports:
//   master : the side that feeds windows and coefficients and consumes results
//   slave  : the convolution pipeline itself
// -----------------------------------------------------------------------------
interface gabor_conv_pipe_if #(
  parameter int KERNEL_SIZE = 5,
  parameter int PIX_W       = 9,
  parameter int COEFF_W     = 17,
  parameter int OUT_W       = 26
) ();

  logic                                 in_valid;
  logic                                 in_ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0] in_window;
  logic                                 coeff_we;
  logic [2:0]                           coeff_addr;
  logic [COEFF_W-1:0]                   coeff_wdata;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [OUT_W-1:0]                     out_data;
  logic                                 out_sat;

  modport master (
    output in_valid, in_window, coeff_we, coeff_addr, coeff_wdata, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_window, coeff_we, coeff_addr, coeff_wdata, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/gabor_conv_pipe.sv
// -----------------------------------------------------------------------------
// gabor_conv_pipe
//
// Purpose: pipelined grouped-coefficient Gabor convolution. One
// KERNEL_SIZE x KERNEL_SIZE window is accepted per beat; pixels that share a
// coefficient (GROUP_MAP) are summed, each group sum is multiplied by its
// programmable coefficient, and the products are reduced, rounded, shifted
// down by COEFF_FRAC and limited to OUT_W bits.
//
// Pipeline (register after each step):
//   s1  group sums + snapshot of the whole coefficient bank (accept edge)
//   s2  per-group exact products
//   s3  exact sum of products
//   out rounding, fraction drop and range limit
// A beat accepted at edge N is presented on out_valid after edge N+3.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gabor_conv_pipe_if.slave (window stream, coefficient writes,
//          result stream)
//
// Optional feature: define CONV_SAT_EN to clip out-of-range results to the
// nearest OUT_W bound and flag them on out_sat. Without it the result wraps
// (low OUT_W bits) and out_sat stays 0.
// -----------------------------------------------------------------------------
module gabor_conv_pipe #(
  parameter int KERNEL_SIZE = 5,
  parameter int NUM_GROUPS  = 5,
  // Group index per pixel, 3 bits each, pixel 0 at the LSBs.
  parameter logic [3*KERNEL_SIZE*KERNEL_SIZE-1:0] GROUP_MAP = {
    3'd0, 3'd0, 3'd0,              // pixels 24..22
    3'd1, 3'd1,                    // 21..20
    3'd2, 3'd2,                    // 19..18
    3'd3, 3'd3, 3'd3,              // 17..15
    3'd4, 3'd4, 3'd4, 3'd4, 3'd4,  // 14..10
    3'd3, 3'd3, 3'd3,              // 9..7
    3'd2, 3'd2,                    // 6..5
    3'd1, 3'd1,                    // 4..3
    3'd0, 3'd0, 3'd0               // 2..0
  },
  parameter int PIX_W      = 9,
  parameter int COEFF_INT  = 2,
  parameter int COEFF_FRAC = 15,
  parameter int SUM_W      = 12,
  parameter int OUT_W      = 26,
  parameter int ROUND      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  gabor_conv_pipe_if.slave  bus
);

  localparam int NPIX    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int COEFF_W = COEFF_INT + COEFF_FRAC;
  localparam int PROD_W  = COEFF_W + SUM_W;
  localparam int ACC_W   = PROD_W + 3;
  // One bit wider than both the accumulator and the output so the rounding
  // add cannot overflow and the range compare sees the true value.
  localparam int EXT_W   = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] RND_EXT =
    (ROUND != 0) ? (EXT_W'(1) <<< (COEFF_FRAC - 1)) : '0;

  typedef logic signed [PIX_W-1:0]   pix_t;
  typedef logic signed [SUM_W-1:0]   sum_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [OUT_W-1:0]   out_t;

  logic   stall;

  coeff_t coeff_q    [NUM_GROUPS];

  sum_t   grp_sum_d  [NUM_GROUPS];
  logic   s1_valid_q;
  sum_t   s1_sum_q   [NUM_GROUPS];
  coeff_t s1_coeff_q [NUM_GROUPS];

  prod_t  s2_prod_d  [NUM_GROUPS];
  logic   s2_valid_q;
  prod_t  s2_prod_q  [NUM_GROUPS];

  acc_t   acc_d;
  logic   s3_valid_q;
  acc_t   s3_acc_q;

  out_t   out_data_d;
  logic   out_sat_d;
  logic   out_valid_q;
  out_t   out_data_q;
  logic   out_sat_q;

  // The whole pipeline freezes only when the output register holds a result
  // nobody takes; bubbles upstream are not squeezed out during a stall.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // Group sums: each pixel is sign-extended and added into its group; the
  // sum wraps at SUM_W bits. Map entries >= NUM_GROUPS contribute nothing.
  always_comb begin
    pix_t pix;
    pix = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_sum_d[g] = '0;
    end
    for (int p = 0; p < NPIX; p++) begin
      pix = bus.in_window[p*PIX_W +: PIX_W];
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (GROUP_MAP[3*p +: 3] == 3'(g)) begin
          grp_sum_d[g] = grp_sum_d[g] + SUM_W'(pix);
        end
      end
    end
  end

  // Products are exact at PROD_W: both operands are sign-extended first.
  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      s2_prod_d[g] = PROD_W'(s1_sum_q[g]) * PROD_W'(s1_coeff_q[g]);
    end
  end

  // Three guard bits cover up to eight groups without overflow.
  always_comb begin
    acc_d = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      acc_d = acc_d + ACC_W'(s2_prod_q[g]);
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    shifted    = (EXT_W'(s3_acc_q) + RND_EXT) >>> COEFF_FRAC;
    out_data_d = shifted[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (shifted > OUT_MAX) begin
      out_data_d = OUT_MAX[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end else if (shifted < OUT_MIN) begin
      out_data_d = OUT_MIN[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end
  end
`else
  // Out-of-range results wrap: only the low OUT_W bits are kept.
  always_comb begin
    out_data_d = OUT_W'((EXT_W'(s3_acc_q) + RND_EXT) >>> COEFF_FRAC);
    out_sat_d  = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        coeff_q[g]    <= '0;
        s1_sum_q[g]   <= '0;
        s1_coeff_q[g] <= '0;
        s2_prod_q[g]  <= '0;
      end
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // The bank updates even during a stall; beats already in flight carry
      // their own snapshot, and a beat accepted on the write edge sees the
      // old value.
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (bus.coeff_we && (bus.coeff_addr == 3'(g))) begin
          coeff_q[g] <= bus.coeff_wdata;
        end
      end
      if (!stall) begin
        s1_valid_q <= bus.in_valid;
        for (int g = 0; g < NUM_GROUPS; g++) begin
          s1_sum_q[g]   <= grp_sum_d[g];
          s1_coeff_q[g] <= coeff_q[g];
          s2_prod_q[g]  <= s2_prod_d[g];
        end
        s2_valid_q  <= s1_valid_q;
        s3_valid_q  <= s2_valid_q;
        s3_acc_q    <= acc_d;
        out_valid_q <= s3_valid_q;
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
      end
    end
  end

endmodule

// File: tb/tb_gabor_conv_pipe.sv
// -----------------------------------------------------------------------------
// tb_gabor_conv_pipe
//
// Two instances share one stimulus stream: dut_a with the default build
// (OUT_W 26, rounding) and dut_b with OUT_W 12 and truncation, so the wrap /
// clip boundary and both rounding modes are exercised together. Expected
// results come from a reference model that computes the convolution from the
// group table with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_gabor_conv_pipe;

  localparam int K       = 5;
  localparam int NPIX    = K * K;
  localparam int NG      = 5;
  localparam int PIX_W   = 9;
  localparam int COEFF_W = 17;
  localparam int OUT_W_A = 26;
  localparam int OUT_W_B = 12;
`ifdef CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- stimulus
  logic                    in_valid    = 1'b0;
  logic                    out_ready   = 1'b1;
  logic                    coeff_we    = 1'b0;
  logic [2:0]              coeff_addr  = '0;
  logic [COEFF_W-1:0]      coeff_wdata = '0;
  logic [NPIX*PIX_W-1:0]   in_window   = '0;

  gabor_conv_pipe_if #(.KERNEL_SIZE(K), .PIX_W(PIX_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W_A)) bus_a ();
  gabor_conv_pipe_if #(.KERNEL_SIZE(K), .PIX_W(PIX_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W_B)) bus_b ();

  assign bus_a.in_valid    = in_valid;
  assign bus_a.in_window   = in_window;
  assign bus_a.coeff_we    = coeff_we;
  assign bus_a.coeff_addr  = coeff_addr;
  assign bus_a.coeff_wdata = coeff_wdata;
  assign bus_a.out_ready   = out_ready;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.in_window   = in_window;
  assign bus_b.coeff_we    = coeff_we;
  assign bus_b.coeff_addr  = coeff_addr;
  assign bus_b.coeff_wdata = coeff_wdata;
  assign bus_b.out_ready   = out_ready;

  gabor_conv_pipe dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  gabor_conv_pipe #(.OUT_W(OUT_W_B), .ROUND(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [64:0] exp_a_q[$];
  logic [64:0] exp_b_q[$];
  longint      coeff_m [NG];
  int          n_out_a = 0;
  int          n_out_b = 0;
  bit          hold_pending = 1'b0;
  longint      held_a, held_b;
  logic [64:0] e_a, e_b;

  // Group of each pixel (90 degree symmetric map).
  int grp_of [NPIX] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 4, 4, 4,
                        3, 3, 3, 2, 2, 1, 1, 0, 0, 0};

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_to(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Returns {sat, result} for the current coefficient model.
  function automatic logic [64:0] model(input logic [NPIX*PIX_W-1:0] win,
                                        input int out_w, input bit rnd);
    longint gs [NG];
    longint acc, sh, hi, lo, lim;
    bit sat;
    logic [PIX_W-1:0] praw;
    for (int g = 0; g < NG; g++) gs[g] = 0;
    for (int p = 0; p < NPIX; p++) begin
      praw = win[p*PIX_W +: PIX_W];
      gs[grp_of[p]] += longint'($signed(praw));
    end
    acc = 0;
    for (int g = 0; g < NG; g++) acc += wrap_to(gs[g], 12) * coeff_m[g];
    if (rnd) acc += longint'(1) << 14;
    sh  = acc >>> 15;
    hi  = (longint'(1) << (out_w - 1)) - 1;
    lo  = -(longint'(1) << (out_w - 1));
    sat = 1'b0;
    if (SAT_EN) begin
      if (sh > hi) begin lim = hi; sat = 1'b1; end
      else if (sh < lo) begin lim = lo; sat = 1'b1; end
      else lim = sh;
    end else begin
      lim = wrap_to(sh, out_w);
    end
    return {sat, lim};
  endfunction

  // Monitor: sampled mid-cycle where every input and output is settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && bus_a.in_ready) begin
        exp_a_q.push_back(model(in_window, OUT_W_A, 1'b1));
        exp_b_q.push_back(model(in_window, OUT_W_B, 1'b0));
      end
      // A write on the accept edge is applied after the beat's expectation.
      if (coeff_we && coeff_addr < 3'd5) coeff_m[coeff_addr] = longint'($signed(coeff_wdata));

      check("in_ready_a", bus_a.in_ready, !(bus_a.out_valid && !out_ready));
      check("in_ready_b", bus_b.in_ready, !(bus_b.out_valid && !out_ready));

      if (hold_pending) begin
        check("hold_valid_a", bus_a.out_valid, 1);
        check("hold_data_a", $signed(bus_a.out_data), held_a);
        check("hold_data_b", $signed(bus_b.out_data), held_b);
      end

      if (bus_a.out_valid && out_ready) begin
        n_checks++;
        assert (exp_a_q.size() > 0) else begin
          n_errors++;
          $error("FAIL out_a_unexpected: observed result %0d, expected no result", $signed(bus_a.out_data));
        end
        if (exp_a_q.size() > 0) begin
          e_a = exp_a_q.pop_front();
          check("out_a_data", $signed(bus_a.out_data), $signed(e_a[63:0]));
          check("out_a_sat", bus_a.out_sat, e_a[64]);
          n_out_a++;
        end
      end
      if (bus_b.out_valid && out_ready) begin
        n_checks++;
        assert (exp_b_q.size() > 0) else begin
          n_errors++;
          $error("FAIL out_b_unexpected: observed result %0d, expected no result", $signed(bus_b.out_data));
        end
        if (exp_b_q.size() > 0) begin
          e_b = exp_b_q.pop_front();
          check("out_b_data", $signed(bus_b.out_data), $signed(e_b[63:0]));
          check("out_b_sat", bus_b.out_sat, e_b[64]);
          n_out_b++;
        end
      end

      hold_pending = bus_a.out_valid && !out_ready;
      held_a = $signed(bus_a.out_data);
      held_b = $signed(bus_b.out_data);
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_coeff(input int g, input logic [COEFF_W-1:0] v);
    coeff_we    = 1'b1;
    coeff_addr  = 3'(g);
    coeff_wdata = v;
    step();
    coeff_we    = 1'b0;
  endtask

  task automatic write_all(input logic [COEFF_W-1:0] v);
    for (int g = 0; g < NG; g++) write_coeff(g, v);
  endtask

  function automatic logic [NPIX*PIX_W-1:0] flat_window(input int v);
    logic [NPIX*PIX_W-1:0] w;
    for (int p = 0; p < NPIX; p++) w[p*PIX_W +: PIX_W] = PIX_W'(v);
    return w;
  endfunction

  function automatic logic [NPIX*PIX_W-1:0] rand_window();
    logic [NPIX*PIX_W-1:0] w;
    for (int p = 0; p < NPIX; p++) w[p*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 511));
    return w;
  endfunction

  // Sends one beat (accepted on the next edge) and checks the exact latency.
  task automatic single_beat(input string tag, input logic [NPIX*PIX_W-1:0] w,
                             input longint da, input longint sa,
                             input longint db, input longint sb);
    in_window = w;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    check({tag, "_valid_n1"}, bus_a.out_valid, 0);
    step();
    check({tag, "_valid_n2"}, bus_a.out_valid, 0);
    step();
    check({tag, "_valid_n3"}, bus_a.out_valid, 0);
    step();
    check({tag, "_valid_a"}, bus_a.out_valid, 1);
    check({tag, "_data_a"}, $signed(bus_a.out_data), da);
    check({tag, "_sat_a"}, bus_a.out_sat, sa);
    check({tag, "_valid_b"}, bus_b.out_valid, 1);
    check({tag, "_data_b"}, $signed(bus_b.out_data), db);
    check({tag, "_sat_b"}, bus_b.out_sat, sb);
    step();
  endtask

  task automatic drain(input string tag);
    int d;
    d = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && d < 40) begin
      step();
      d++;
    end
    check({tag, "_drain_a"}, exp_a_q.size(), 0);
    check({tag, "_drain_b"}, exp_b_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int c, acc, base;
    bit got;
    for (int g = 0; g < NG; g++) coeff_m[g] = 0;

    // Reset state.
    #1;
    check("rst_valid_a", bus_a.out_valid, 0);
    check("rst_data_a", $signed(bus_a.out_data), 0);
    check("rst_sat_a", bus_a.out_sat, 0);
    check("rst_in_ready_a", bus_a.in_ready, 1);
    check("rst_valid_b", bus_b.out_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // All ones, all coefficients 1.0.
    write_all(17'd32768);
    single_beat("unity", flat_window(1), 25, 0, 25, 0);

    // 255 in every pixel, only the centre row group at 1.5.
    write_all(17'd0);
    write_coeff(4, 17'd49152);
    single_beat("round", flat_window(255), 1913, 0, 1912, 0);

    // -256 everywhere with -2.0 coefficients: 12800 exceeds a 12-bit output.
    write_all(17'h10000);
    single_beat("range", flat_window(-256), 12800, 0,
                SAT_EN ? 2047 : 512, SAT_EN ? 1 : 0);

    // Coefficient write on the accept edge: first beat sees the old value.
    write_all(17'd0);
    in_window   = flat_window(1);
    in_valid    = 1'b1;
    coeff_we    = 1'b1;
    coeff_addr  = 3'd0;
    coeff_wdata = 17'd32768;
    step();
    coeff_we    = 1'b0;
    step();
    in_valid    = 1'b0;
    step();
    step();
    check("wr_first_valid", bus_a.out_valid, 1);
    check("wr_first_data", $signed(bus_a.out_data), 0);
    step();
    check("wr_second_valid", bus_a.out_valid, 1);
    check("wr_second_data", $signed(bus_a.out_data), 6);
    step();

    // Ten beats back to back with the sink stalled on cycles 4-7.
    for (int g = 0; g < NG; g++) write_coeff(g, 17'($urandom));
    base = n_out_a;
    c = 0;
    acc = 0;
    while (acc < 10 && c < 100) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = 1'b1;
      if (c == 0 || got) in_window = rand_window();
      #1;
      got = bus_a.in_ready;
      step();
      if (got) acc++;
      c++;
    end
    check("stream_accepted", acc, 10);
    drain("stream");
    check("stream_count_a", n_out_a - base, 10);

    // Random traffic: random sink stalls and coefficient writes (some to
    // unused addresses), valid held until each beat is taken.
    for (int i = 0; i < 120; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        in_window = rand_window();
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      coeff_we    = ($urandom_range(0, 3) == 0);
      coeff_addr  = 3'($urandom_range(0, 7));
      coeff_wdata = 17'($urandom);
      #1;
      got = bus_a.in_ready;
      step();
      if (in_valid && got) in_valid = 1'b0;
    end
    coeff_we = 1'b0;
    drain("random");

    // Reset with three beats in flight.
    write_all(17'd32768);
    in_window = flat_window(1);
    in_valid  = 1'b1;
    step();
    step();
    step();
    in_valid  = 1'b0;
    step();
    check("mid_valid_before", bus_a.out_valid, 1);
    check("mid_data_before", $signed(bus_a.out_data), 25);
    rst_n = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int g = 0; g < NG; g++) coeff_m[g] = 0;
    #1;
    check("mid_rst_valid_a", bus_a.out_valid, 0);
    check("mid_rst_data_a", $signed(bus_a.out_data), 0);
    check("mid_rst_sat_b", bus_b.out_sat, 0);
    check("mid_rst_in_ready", bus_a.in_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_idle_a", bus_a.out_valid, 0);
      check("post_rst_idle_b", bus_b.out_valid, 0);
    end
    single_beat("post_rst_coeff", flat_window(1), 0, 0, 0, 0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gabor_conv_pipe.md
# gabor_conv_pipe

Pipelined, parametrised successor to the combinational grouped-coefficient Gabor convolution block. It accepts one KERNEL_SIZE×KERNEL_SIZE pixel window per beat, sums pixels sharing a coefficient (symmetry groups set by a compile-time map), multiplies each group sum by a runtime-programmable coefficient, and reduces the products to a single rounded, range-limited output sample. It sits between the line-buffer window generator and the orientation-magnitude combiner, with valid/ready flow control on both sides.

## Interface
- KERNEL_SIZE, 5, window side; window holds KERNEL_SIZE² pixels
- NUM_GROUPS, 5, number of distinct coefficients (1..8)
- GROUP_MAP, 90° map, packed 3 bits per pixel (pixel 0 = LSBs), group index per pixel; default: pixels 0-2,22-24→0; 3,4,20,21→1; 5,6,18,19→2; 7-9,15-17→3; 10-14→4
- PIX_W, 9, signed pixel width
- COEFF_INT, 2, coefficient integer bits incl. sign
- COEFF_FRAC, 15, coefficient fraction bits; COEFF_W = COEFF_INT+COEFF_FRAC
- SUM_W, 12, signed group-sum width
- OUT_W, 26, signed output width
- ROUND, 1, 1 = round-half-up on fraction drop, 0 = truncate
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  window beat valid
- in_ready  out  1  block accepts beat this cycle
- in_window  in  KERNEL_SIZE²·PIX_W  signed pixels, pixel 0 at LSBs
- coeff_we  in  1  coefficient write strobe
- coeff_addr  in  3  group index to write
- coeff_wdata  in  COEFF_W  signed coefficient
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed result
- out_sat  out  1  out_data was clipped (always 0 without CONV_SAT_EN)

## Operation
- Coefficient bank: NUM_GROUPS registers, reset to 0. coeff_we writes coeff_addr; addr ≥ NUM_GROUPS ignored. Write visible to beats accepted the following cycle onward.
- S1 (accept, in_valid && in_ready): register per-group sums (pixels sign-extended to SUM_W, summed modulo 2^SUM_W) and snapshot the full coefficient bank with the beat.
- S2: per-group product, signed, PROD_W = COEFF_W+SUM_W, exact.
- S3: sum products at ACC_W = PROD_W+3, exact; if ROUND add 2^(COEFF_FRAC-1); arithmetic shift right COEFF_FRAC; limit to OUT_W (see Configuration); register out_data, out_sat.
- Flow control: stall = out_valid && !out_ready; in_ready = !stall (combinational). On stall all stages hold; no beat dropped or duplicated. Bubbles propagate as valid=0.
- Coefficient write during stall: bank updates; in-flight beats keep their snapshot.

## Timing
- Latency: beat accepted at edge N appears on out_valid after edge N+3 (no stall). Throughput 1 beat/cycle with out_ready high.
- Reset (async assert, sync-safe deassert): all stage valids 0, out_valid 0, out_data 0, out_sat 0, coefficients 0; in_ready = 1 while out_valid = 0.
- Reset mid-stream: in-flight beats discarded; no out_valid after deassertion until a new beat is accepted.
- Simultaneous coeff_we and accept in same cycle: accepted beat uses the old coefficient.
- out_data/out_sat stable while out_valid && !out_ready.

## Configuration
- CONV_SAT_EN defined: shifted accumulator outside [−2^(OUT_W−1), 2^(OUT_W−1)−1] clips to the nearest bound, out_sat = 1 for that beat.
- CONV_SAT_EN undefined: low OUT_W bits taken (two's-complement wrap), out_sat tied 0.

## Test plan
- All pixels 1, all coefficients 32768 (1.0) → out_data 25 exactly 3 cycles after accept, out_sat 0.
- All pixels 255, coefficient group 4 = 49152 (1.5), others 0 → out_data 1913 (5·255·1.5 = 1912.5, rounded up); with ROUND=0 → 1912.
- Pixels −256, all coefficients −65536 (−2.0), OUT_W=12 → with CONV_SAT_EN out_data 2047, out_sat 1; without → out_data 12800 mod 4096 = 512, out_sat 0.
- Stream 10 beats, out_ready low for cycles 4-7 → in_ready low exactly while out_valid && !out_ready, 10 results in order, none lost/duplicated, out_data held during stall.
- coeff_we changes group 0 from 0 to 32768 in the same cycle a beat is accepted, next beat follows → first result uses 0, second uses 1.0.
- Assert rst_n low with 3 beats in flight → outputs zero immediately; after release no out_valid until new in_valid accepted; coefficients read 0.
